// File: rtl/mem_store_buffer_pkg.sv
// Shared types for the MEM-stage store buffer: pipeline bus, memory op encodings,
// store buffer entry layout and drain FSM states.
package mem_store_buffer_pkg;
  localparam int XLEN            = 32;
  localparam int BE_W            = 4;
  localparam int LANE_W          = 8;
  localparam int MEM_OP_BITS     = 4;
  localparam int STORE_BUF_DEPTH = 2;

  // Top bit of mem_op separates stores from loads.
  localparam logic STORE_PRFX = 1'b1;
  localparam logic LOAD_PRFX  = 1'b0;

  typedef enum logic [MEM_OP_BITS-1:0] {
    MEM_NOP = 4'h0,
    MEM_LB  = 4'h1,
    MEM_LH  = 4'h2,
    MEM_LW  = 4'h3,
    MEM_LBU = 4'h4,
    MEM_LHU = 4'h5,
    MEM_SB  = 4'h9,
    MEM_SH  = 4'hA,
    MEM_SW  = 4'hB
  } mem_op_t;

  typedef struct packed {
    mem_op_t         mem_op;
    logic [XLEN-1:0] rd_res;
    logic [XLEN-1:0] rs2_data;
    logic            pipeline_stall;
  } pipeline_bus_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } store_entry_t;

  typedef enum logic {SB_IDLE, SB_REQ} sb_state_t;
endpackage

// File: rtl/mem_store_buffer_store_lane_fmt.sv
// Store lane formatter: turns a store op and the low address bits into byte
// enables, lane-replicated write data and a misalignment flag.
module store_lane_fmt
  import mem_store_buffer_pkg::*;
(
  input  logic [MEM_OP_BITS-1:0] mem_op,
  input  logic [1:0]             a,
  input  logic [XLEN-1:0]        d,
  output logic [BE_W-1:0]        be,
  output logic [XLEN-1:0]        wdata,
  output logic                   misaligned
);
  always_comb begin
    be         = '0;
    wdata      = d;
    misaligned = 1'b0;
    case (mem_op)
      MEM_SB: begin
        be    = 4'b0001 << a;
        wdata = {4{d[LANE_W-1:0]}};
      end
      MEM_SH: begin
        be         = a[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{d[2*LANE_W-1:0]}};
        misaligned = a[0];
      end
      MEM_SW: begin
        be         = 4'b1111;
        misaligned = |a;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: formats stores, queues them in a small FIFO and drains
// them over a req/gnt handshake. Optional trap on misaligned stores: MISALIGN_TRAP_EN.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = STORE_BUF_DEPTH,
  parameter int ADDR_W = XLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  pipeline_bus_t     bus_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [BE_W-1:0]   dmem_be_o,
  input  logic              dmem_gnt_i,
  output logic              empty_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + XLEN + BE_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic              store_vld, load_vld, store_ok, push, pop, full, mis;
  logic [BE_W-1:0]   be, h_be;
  logic [XLEN-1:0]   wdata, h_wdata;
  logic [ADDR_W-1:0] h_addr;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic [EW-1:0]     mem_q [DEPTH];
  sb_state_t         state;

  store_lane_fmt u_fmt (
    .mem_op     (bus_i.mem_op),
    .a          (bus_i.rd_res[1:0]),
    .d          (bus_i.rs2_data),
    .be         (be),
    .wdata      (wdata),
    .misaligned (mis)
  );

  assign store_vld = (bus_i.mem_op != MEM_NOP) && (bus_i.mem_op[MEM_OP_BITS-1] == STORE_PRFX)
                     && !bus_i.pipeline_stall;
  assign load_vld  = (bus_i.mem_op != MEM_NOP) && (bus_i.mem_op[MEM_OP_BITS-1] == LOAD_PRFX)
                     && !bus_i.pipeline_stall;

`ifdef MISALIGN_TRAP_EN
  // A misaligned store traps instead of queueing, so it never stalls on a full buffer.
  assign store_ok = store_vld && !mis;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      misalign_o <= store_vld && mis;
      if (store_vld && mis) misalign_addr_o <= bus_i.rd_res[ADDR_W-1:0];
    end
  end
`else
  logic mis_unused;
  assign mis_unused      = mis;
  assign store_ok        = store_vld;
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

  // Full is judged on the registered count only, keeping gnt out of the stall path.
  assign full      = (count == FULL_CNT);
  assign push      = store_ok && !full;
  assign pop       = (state == SB_REQ) && dmem_gnt_i;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign stall_o   = (store_ok && full) || (load_vld && (count != '0));
  assign empty_o   = (count == '0);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr] <= {bus_i.rd_res[ADDR_W-1:2], 2'b00, wdata, be};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= SB_IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      case (state)
        SB_IDLE: if (count_nxt != '0) state <= SB_REQ;
        SB_REQ:  if (count_nxt == '0) state <= SB_IDLE;
        default: state <= SB_IDLE;
      endcase
    end
  end

  assign {h_addr, h_wdata, h_be} = mem_q[rd_ptr];
  assign dmem_req_o   = (state == SB_REQ);
  assign dmem_addr_o  = dmem_req_o ? h_addr  : '0;
  assign dmem_wdata_o = dmem_req_o ? h_wdata : '0;
  assign dmem_be_o    = dmem_req_o ? h_be    : '0;
endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Store-side counterpart of the load result path in MEM.
- Accepts store ops from the pipeline bus, aligns write data into byte lanes and generates byte enables.
- Queues stores in a small FIFO and drains them to data memory over a req/gnt handshake.
- Stalls the pipeline when the FIFO is full, and stalls loads until all older stores have drained, to keep memory ordering.

Parameters:
- DEPTH, 2, number of store buffer entries; power of two, at least 2.
- ADDR_W, 32, data memory byte address width.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; asynchronous, active-high.
- bus_i  in  core::pipeline_bus_t  EX/MEM bus. The effective address is in rd_res. Store data is in rs2_data.
- stall_o  out  1  pipeline stall request (combinational).
- dmem_req_o  out  1  write request valid.
- dmem_addr_o  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- dmem_wdata_o  out  32  lane-replicated write data.
- dmem_be_o  out  4  byte enables.
- dmem_gnt_i  in  1  memory accepts the current request this cycle.
- empty_o  out  1  buffer holds no stores.
- misalign_o  out  1  misaligned store flag (optional feature only).
- misalign_addr_o  out  ADDR_W  faulting address (optional feature only).

Behaviour:
- Store valid = mem_op != MEM_NOP && mem_op[MEM_OP_BITS-1] == STORE_PRFX && !pipeline_stall.
- Load valid uses the same rule with LOAD_PRFX.
- Lane formatting, with a = rd_res[1:0] and d = rs2_data:
  - SB: be = 4'b0001 << a; wdata = {4{d[7:0]}}.
  - SH: be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{d[15:0]}}.
  - SW: be = 4'b1111; wdata = d.
- Entry contents: {word addr, wdata, be}, ADDR_W+36 bits.
- Push:
  - Occurs on a store-valid cycle when count < DEPTH.
  - Write pointer and count update at the clock edge.
- stall_o = (store valid && count == DEPTH) || (load valid && count != 0).
  - No combinational path from dmem_gnt_i to stall_o. A push is refused when full even if a pop happens in the same cycle.
- Drain FSM:
  - IDLE: dmem_req_o = 0. Go to REQ when count becomes non-zero; the earliest request is one cycle after the first push.
  - REQ: dmem_req_o = 1 and the outputs present the head entry. Outputs hold stable until dmem_gnt_i.
  - On gnt: pop, and advance to the next entry in the following cycle. Stay in REQ if the remaining count (including a same-cycle push) is > 0, else return to IDLE.
- Simultaneous push and pop when count < DEPTH: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. full/empty are decided by count, which is log2(DEPTH)+1 bits.
- Reset: state = IDLE, pointers and count = 0, all outputs 0, empty_o = 1. Reset mid-transaction discards all queued stores; memory must tolerate a dropped request.
- Latency: push to first dmem_req_o is 1 cycle. Each entry's throughput is 1 per cycle while gnt stays high.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned store (SH with a[0] = 1, or SW with a != 0) is not pushed.
  - misalign_o pulses high for exactly one cycle, registered, and misalign_addr_o captures rd_res.
  - Both outputs reset to 0.
- Undefined:
  - Low address bits beyond the access size are ignored. SH uses a[1] only; SW is forced to be = 1111.
  - misalign_o and misalign_addr_o are tied to 0.

Decomposition:
- core package additions:
  - store_entry_t struct {addr, wdata, be}.
  - sb_state_t enum {SB_IDLE, SB_REQ}.
  - STORE_BUF_DEPTH constant.
  - Shared byte-enable widths.
- One sub-module: store_lane_fmt, combinational. It maps mem_op and rd_res[1:0] to be, wdata and misaligned.

Test Plan:
- SB at addr 0x103, rs2_data 0xAABBCCDD, gnt = 1 → next cycle req = 1, addr = 0x100, be = 1000, wdata = 0xDDDDDDDD; empty_o = 1 one cycle after gnt.
- SH at 0x202, data 0x1234, then SW at 0x300, data 0xCAFEBABE, gnt = 0 → buffer full. A third store raises stall_o and is not pushed. Raising gnt drains be 1100/0x12341234, then 1111/0xCAFEBABE, in order.
- Load (LW) arrives with 1 store queued → stall_o = 1 until the cycle the store is granted and count reaches 0. Then stall_o = 0.
- gnt held low for 5 cycles → addr, wdata and be remain stable throughout. Pop only on the gnt cycle.
- Assert rst_i asynchronously with 2 entries queued and req = 1 → req, count and stall drop immediately. No request after reset release.
- MISALIGN_TRAP_EN defined: SW at 0x401 → misalign_o = 1 for one cycle, misalign_addr_o = 0x401, no dmem_req_o. Undefined: SW at 0x401 → be = 1111, addr 0x400.
